// File: rtl/regfile_pkg.sv
// Shared types and parameter defaults for the parametrised register file.
package regfile_pkg;

   localparam int unsigned WIDTH_DEF    = 32;
   localparam int unsigned DEPTH_DEF    = 4;
   localparam bit          BYPASS_DEF   = 1'b1;
   localparam bit          ZERO_REG_DEF = 1'b0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/regfile_param_reg_word.sv
// One WIDTH-bit storage word: synchronous clear has priority over load.
module reg_word #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with a post-reset zeroing sweep, optional
// write-to-read forwarding and an optional hardwired-zero register 0.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter bit          BYPASS   = BYPASS_DEF,
   parameter bit          ZERO_REG = ZERO_REG_DEF,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_req,
   input  logic             regWrite,
   input  logic [AW-1:0]    writereg,
   input  logic [WIDTH-1:0] writedata,
   input  logic [AW-1:0]    readreg1,
   input  logic [AW-1:0]    readreg2,
   output logic [WIDTH-1:0] readdata1,
   output logic [WIDTH-1:0] readdata2,
   output logic             ready,
   output logic             wr_drop
);

   state_t           state;
   state_t           state_nxt;
   logic [AW-1:0]    sweep_cnt;
   logic [AW-1:0]    sweep_nxt;
   logic             drop_nxt;
   logic [DEPTH-1:0] word_clr;
   logic [DEPTH-1:0] word_load;
   logic [WIDTH-1:0] words [DEPTH];
   logic             fwd1;
   logic             fwd2;

   // State register; storage words are deliberately not touched by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         sweep_cnt <= '0;
         wr_drop   <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep_cnt <= sweep_nxt;
         wr_drop   <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sweep_nxt = sweep_cnt;
      drop_nxt  = wr_drop;
      unique case (state)
         CLEAR: begin
            // Counter wraps to 0 exactly on the last-word edge (DEPTH is 2^AW).
            sweep_nxt = sweep_cnt + 1'b1;
            if (sweep_cnt == AW'(DEPTH - 1)) begin
               state_nxt = RUN;
            end
            if (regWrite) begin
               drop_nxt = 1'b1;
            end
         end
         RUN: begin
            if (clear_req) begin
               state_nxt = CLEAR;
               sweep_nxt = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            sweep_nxt = '0;
         end
      endcase
   end

   always_comb begin
      ready     = (state == RUN);
      word_clr  = '0;
      word_load = '0;
      if (!reset) begin
         if (state == CLEAR) begin
            word_clr[sweep_cnt] = 1'b1;
         end else if (regWrite && !(ZERO_REG && writereg == '0)) begin
            word_load[writereg] = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if (ZERO_REG && i == 0) begin : g_zero
         assign words[i] = '0;
      end else begin : g_reg
         reg_word #(
            .WIDTH (WIDTH)
         ) u_word (
            .clk   (clk),
            .reset (word_clr[i]),
            .load  (word_load[i]),
            .d     (writedata),
            .q     (words[i])
         );
      end
   end

   always_comb begin
      fwd1 = BYPASS && ready && regWrite && (writereg == readreg1);
      fwd2 = BYPASS && ready && regWrite && (writereg == readreg2);

      readdata1 = fwd1 ? writedata : words[readreg1];
      if (!ready || (ZERO_REG && readreg1 == '0)) begin
         readdata1 = '0;
      end

      readdata2 = fwd2 ? writedata : words[readreg2];
      if (!ready || (ZERO_REG && readreg2 == '0)) begin
         readdata2 = '0;
      end
   end

endmodule
